// File: rtl/adv7513_pkg.sv
// Shared types and constants for the ADV7513 register-setup sequencer.
package adv7513_pkg;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_WAIT_HPD,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [2:0] I2C_STATUS_OK = 3'd0;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    localparam cfg_entry_t CFG_DEFAULT = '{reg_addr: 8'h41, data: 8'h10};

    function automatic cfg_entry_t cfg_entry(input logic [7:0] reg_addr, input logic [7:0] data);
        return '{reg_addr: reg_addr, data: data};
    endfunction

endpackage

// File: rtl/adv7513_cfg_rom.sv
// Registered configuration ROM for the ADV7513: one (reg,data) pair per table index, 1-cycle read.
module adv7513_cfg_rom
    import adv7513_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    output cfg_entry_t q
);

    cfg_entry_t rd_d;
    cfg_entry_t rd_q;

    always_comb begin
        case (addr)
            8'd0:    rd_d = cfg_entry(8'h41, 8'h10);  // power up the TX core
            8'd1:    rd_d = cfg_entry(8'h98, 8'h03);
            8'd2:    rd_d = cfg_entry(8'h9A, 8'hE0);
            8'd3:    rd_d = cfg_entry(8'h9C, 8'h30);
            8'd4:    rd_d = cfg_entry(8'h9D, 8'h61);
            8'd5:    rd_d = cfg_entry(8'hA2, 8'hA4);
            8'd6:    rd_d = cfg_entry(8'hA3, 8'hA4);
            8'd7:    rd_d = cfg_entry(8'hE0, 8'hD0);
            8'd8:    rd_d = cfg_entry(8'hF9, 8'h00);
            8'd9:    rd_d = cfg_entry(8'h15, 8'h00);  // video input/output format
            8'd10:   rd_d = cfg_entry(8'h16, 8'h30);
            8'd11:   rd_d = cfg_entry(8'h17, 8'h02);
            8'd12:   rd_d = cfg_entry(8'h18, 8'h46);
            8'd13:   rd_d = cfg_entry(8'hAF, 8'h06);
            8'd14:   rd_d = cfg_entry(8'h55, 8'h00);
            8'd15:   rd_d = cfg_entry(8'hD6, 8'hC0);
            default: rd_d = CFG_DEFAULT;
        endcase
    end

    // NOTE: the read register is deliberately left without reset; its contents are only
    // consumed after the controller has spent a full S_LOAD cycle addressing it.
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
    end

    assign q = rd_q;

endmodule

// File: rtl/adv7513_cfg_ctrl.sv
// ADV7513 I2C setup sequencer: power-up delay, debounced HPD, table write with retry,
// and automatic re-run of the table on every HPD re-assert or reinit pulse.
module adv7513_cfg_ctrl
    import adv7513_pkg::*;
#(
    parameter logic [6:0]  CHIP_ADDR    = 7'h39,
    parameter int          NUM_REGS     = 16,
    parameter logic [23:0] PWRUP_CYCLES = 24'd10_000_000,
    parameter logic [15:0] HPD_DEBOUNCE = 16'd50_000,
    parameter int          MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hpd,
    input  logic       reinit,
    output logic [6:0] i2c_chip_addr,
    output logic [7:0] i2c_reg_addr,
    output logic [7:0] i2c_data_in,
    output logic       i2c_write_en,
    input  logic       i2c_busy,
    input  logic [2:0] i2c_status,
    output logic       init_done,
    output logic       init_error,
    output logic [7:0] err_index
);

    localparam int         RETRY_W    = $clog2(MAX_RETRY + 1);
    localparam logic [7:0] LAST_INDEX = 8'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [23:0]         pwr_cnt_q, pwr_cnt_d;
    logic                hpd_s1_q, hpd_s1_d;
    logic                hpd_s2_q, hpd_s2_d;
    logic                hpd_last_q, hpd_last_d;
    logic [15:0]         deb_cnt_q, deb_cnt_d;
    logic                hpd_acc_q, hpd_acc_d;
    logic [7:0]          index_q, index_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [2:0]          status_q, status_d;
    logic                first_q, first_d;
    logic                reinit_pend_q, reinit_pend_d;
    logic                write_en_q, write_en_d;
    logic [7:0]          reg_addr_q, reg_addr_d;
    logic [7:0]          data_q, data_d;
    logic                init_done_q, init_done_d;
    logic                init_error_q, init_error_d;
    logic [7:0]          err_index_q, err_index_d;
    logic                abort;
    logic                restart;
    cfg_entry_t          rom_q;

    adv7513_cfg_rom u_rom (
        .clk  (clk),
        .addr (index_q),
        .q    (rom_q)
    );

    // NOTE: next-state logic uses blocking assignments and starts from "hold" defaults so
    // every path assigns every _d signal, which keeps synthesis from inferring latches.
    always_comb begin
        state_d       = state_q;
        pwr_cnt_d     = pwr_cnt_q;
        hpd_s1_d      = hpd;
        hpd_s2_d      = hpd_s1_q;
        hpd_last_d    = hpd_s2_q;
        deb_cnt_d     = deb_cnt_q;
        hpd_acc_d     = hpd_acc_q;
        index_d       = index_q;
        retry_d       = retry_q;
        status_d      = status_q;
        first_d       = first_q;
        reinit_pend_d = reinit_pend_q;
        write_en_d    = 1'b0;
        reg_addr_d    = reg_addr_q;
        data_d        = data_q;
        init_done_d   = init_done_q;
        init_error_d  = init_error_q;
        err_index_d   = err_index_q;
        abort         = 1'b0;
        restart       = 1'b0;

        // Any edge of the synchronised level restarts the stability count.
        if (hpd_s2_q != hpd_last_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == HPD_DEBOUNCE - 16'd1) begin
            hpd_acc_d = hpd_last_q;
        end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
        end

        case (state_q)
            S_PWRUP: begin
                if (pwr_cnt_q == PWRUP_CYCLES - 24'd1) state_d = S_WAIT_HPD;
                else                                   pwr_cnt_d = pwr_cnt_q + 24'd1;
            end
            S_WAIT_HPD: begin
                if (hpd_acc_q) begin
                    state_d = S_LOAD;
                    index_d = '0;
                    retry_d = '0;
                end
            end
            S_LOAD: state_d = S_ISSUE;
            S_ISSUE: begin
                write_en_d = 1'b1;
                reg_addr_d = rom_q.reg_addr;
                data_d     = rom_q.data;
                first_d    = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // busy only rises one cycle after the request is seen by the master
                first_d = 1'b0;
                if (!first_q && !i2c_busy) begin
                    status_d = i2c_status;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (status_q == I2C_STATUS_OK) begin
                    state_d = S_NEXT;
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_ISSUE;
                end else begin
                    init_error_d = 1'b1;
                    err_index_d  = index_q;
                    state_d      = S_ERROR;
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (index_q == LAST_INDEX) begin
                    init_done_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                if (!hpd_acc_q) begin
                    init_done_d = 1'b0;
                    state_d     = S_WAIT_HPD;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_PWRUP;
        endcase

        // An in-flight transaction always completes; reinit seen during it is held pending.
        if (state_q == S_WAIT) begin
            if (reinit) reinit_pend_d = 1'b1;
            if (state_d == S_CHECK && (reinit || reinit_pend_q)) restart = 1'b1;
        end else if (reinit && state_q != S_PWRUP) begin
            restart = 1'b1;
        end else if (!hpd_acc_q && state_q inside {S_LOAD, S_ISSUE, S_CHECK, S_NEXT}) begin
            abort = 1'b1;
        end

        if (restart || abort) begin
            state_d     = S_WAIT_HPD;
            write_en_d  = 1'b0;
            index_d     = '0;
            retry_d     = '0;
            init_done_d = 1'b0;
        end
        if (restart) begin
            init_error_d  = 1'b0;
            err_index_d   = '0;
            reinit_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_PWRUP;
            pwr_cnt_q     <= '0;
            hpd_s1_q      <= 1'b0;
            hpd_s2_q      <= 1'b0;
            hpd_last_q    <= 1'b0;
            deb_cnt_q     <= '0;
            hpd_acc_q     <= 1'b0;
            index_q       <= '0;
            retry_q       <= '0;
            status_q      <= '0;
            first_q       <= 1'b0;
            reinit_pend_q <= 1'b0;
            write_en_q    <= 1'b0;
            reg_addr_q    <= '0;
            data_q        <= '0;
            init_done_q   <= 1'b0;
            init_error_q  <= 1'b0;
            err_index_q   <= '0;
        end else begin
            state_q       <= state_d;
            pwr_cnt_q     <= pwr_cnt_d;
            hpd_s1_q      <= hpd_s1_d;
            hpd_s2_q      <= hpd_s2_d;
            hpd_last_q    <= hpd_last_d;
            deb_cnt_q     <= deb_cnt_d;
            hpd_acc_q     <= hpd_acc_d;
            index_q       <= index_d;
            retry_q       <= retry_d;
            status_q      <= status_d;
            first_q       <= first_d;
            reinit_pend_q <= reinit_pend_d;
            write_en_q    <= write_en_d;
            reg_addr_q    <= reg_addr_d;
            data_q        <= data_d;
            init_done_q   <= init_done_d;
            init_error_q  <= init_error_d;
            err_index_q   <= err_index_d;
        end
    end

    assign i2c_chip_addr = CHIP_ADDR;
    assign i2c_reg_addr  = reg_addr_q;
    assign i2c_data_in   = data_q;
    assign i2c_write_en  = write_en_q;
    assign init_done     = init_done_q;
    assign init_error    = init_error_q;
    assign err_index     = err_index_q;

endmodule

// File: tb/tb_adv7513_cfg_ctrl.sv
// Bench for adv7513_cfg_ctrl: behavioural i2c_master responder, write monitor and a
// table-level reference of the expected write sequence under randomized failure patterns.
module tb_adv7513_cfg_ctrl;

    localparam int NUM_REGS    = 16;
    localparam int MAX_RETRY   = 3;
    localparam int PWRUP       = 100;
    localparam int BUSY_CYCLES = 20;

    localparam logic [15:0] CFG_TBL [NUM_REGS] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
        16'hF900, 16'h1500, 16'h1630, 16'h1702, 16'h1846, 16'hAF06, 16'h5500, 16'hD6C0
    };

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hpd = 1'b0;
    logic       reinit = 1'b0;
    logic [6:0] i2c_chip_addr;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_data_in;
    logic       i2c_write_en;
    logic       i2c_busy = 1'b0;
    logic [2:0] i2c_status = 3'd0;
    logic       init_done;
    logic       init_error;
    logic [7:0] err_index;

    adv7513_cfg_ctrl #(
        .CHIP_ADDR    (7'h39),
        .NUM_REGS     (NUM_REGS),
        .PWRUP_CYCLES (24'd100),
        .HPD_DEBOUNCE (16'd8),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hpd           (hpd),
        .reinit        (reinit),
        .i2c_chip_addr (i2c_chip_addr),
        .i2c_reg_addr  (i2c_reg_addr),
        .i2c_data_in   (i2c_data_in),
        .i2c_write_en  (i2c_write_en),
        .i2c_busy      (i2c_busy),
        .i2c_status    (i2c_status),
        .init_done     (init_done),
        .init_error    (init_error),
        .err_index     (err_index)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // i2c_master model: busy for BUSY_CYCLES, NACKs the first fail_n hits on fail_reg.
    logic [7:0] fail_reg = 8'h00;
    int         fail_n = 0;
    logic       policy_load = 1'b0;
    int         hits = 0;
    int         busy_left = 0;
    logic [2:0] pend_status = 3'd0;

    always @(posedge clk) begin
        if (policy_load) hits <= 0;
        if (i2c_write_en) begin
            i2c_busy  <= 1'b1;
            busy_left <= BUSY_CYCLES;
            if (i2c_reg_addr == fail_reg && hits < fail_n) begin
                pend_status <= 3'($urandom_range(1, 7));
                hits        <= hits + 1;
            end else begin
                pend_status <= 3'd0;
            end
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
                i2c_busy   <= 1'b0;
                i2c_status <= pend_status;
            end
        end
    end

    int since_rst = 0;
    always @(posedge clk) since_rst <= reset ? since_rst + 1 : 0;

    logic [15:0] wr_q[$];
    int          wr_cyc[$];
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (i2c_write_en) begin
            wr_q.push_back({i2c_reg_addr, i2c_data_in});
            wr_cyc.push_back(since_rst);
            check("we_while_busy", 32'(i2c_busy), 32'd0);
            check("we_back_to_back", 32'(prev_we), 32'd0);
        end
        prev_we <= i2c_write_en;
    end

    logic [15:0] exp_q[$];
    int          wr_base = 0;

    // Expected writes: every entry once, a failing entry repeated per retry, stop on exhaustion.
    task automatic build_exp(input int fidx, input int nfail);
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            int reps;
            reps = (i == fidx) ? ((nfail > MAX_RETRY ? MAX_RETRY : nfail) + 1) : 1;
            repeat (reps) exp_q.push_back(CFG_TBL[i]);
            if (i == fidx && nfail > MAX_RETRY) break;
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, 32'(wr_q.size() - wr_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (wr_base + i < wr_q.size())
                check($sformatf("%s_wr%0d", tag, i), 32'(wr_q[wr_base + i]), 32'(exp_q[i]));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reinit();
        @(negedge clk) reinit = 1'b1;
        @(negedge clk) reinit = 1'b0;
    endtask

    task automatic set_policy(input int idx, input int n);
        @(negedge clk);
        fail_reg    = CFG_TBL[idx][15:8];
        fail_n      = n;
        policy_load = 1'b1;
        @(negedge clk);
        policy_load = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(init_done || init_error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(!(init_done || init_error)), 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int total, input int budget);
        int n = 0;
        while (wr_q.size() < total && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(wr_q.size() < total), 32'd0);
    endtask

    task automatic wait_busy_low(input string tag, input int budget);
        int n = 0;
        while (i2c_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(i2c_busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},      32'(i2c_write_en),  32'd0);
        check({tag, "_reg"},     32'(i2c_reg_addr),  32'd0);
        check({tag, "_data"},    32'(i2c_data_in),   32'd0);
        check({tag, "_done"},    32'(init_done),     32'd0);
        check({tag, "_err"},     32'(init_error),    32'd0);
        check({tag, "_erridx"},  32'(err_index),     32'd0);
        check({tag, "_chip"},    32'(i2c_chip_addr), 32'h39);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int fidx;
        int nf;

        // 1: reset with hpd high, power-up hold, full table
        hpd   = 1'b1;
        reset = 1'b0;
        tick(3);
        check_reset_outputs("rst");
        reset = 1'b1;
        wr_base = wr_q.size();
        build_exp(-1, 0);
        wait_end("t1", 1500);
        check_seq("t1");
        if (wr_q.size() > wr_base) check("t1_pwrup_hold", 32'(wr_cyc[wr_base] >= PWRUP), 32'd1);
        check("t1_done", 32'(init_done), 32'd1);
        check("t1_err", 32'(init_error), 32'd0);

        // 2: hpd low after power-up, short glitch, then stable assert
        hpd   = 1'b0;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        wr_base = wr_q.size();
        tick(150);
        check("t2_quiet", 32'(wr_q.size() - wr_base), 32'd0);
        hpd = 1'b1;
        tick($urandom_range(1, 5));
        hpd = 1'b0;
        tick(30);
        check("t2_glitch", 32'(wr_q.size() - wr_base), 32'd0);
        hpd = 1'b1;
        build_exp(-1, 0);
        wait_end("t2", 1500);
        check_seq("t2");
        check("t2_done", 32'(init_done), 32'd1);

        // 3: entry 4 NACKed twice, then recovers
        set_policy(4, 2);
        wr_base = wr_q.size();
        pulse_reinit();
        build_exp(4, 2);
        wait_end("t3", 1500);
        check_seq("t3");
        check("t3_done", 32'(init_done), 32'd1);
        check("t3_err", 32'(init_error), 32'd0);

        // 4: entry 2 NACKed forever, then reinit clears and restarts
        set_policy(2, 1000);
        wr_base = wr_q.size();
        pulse_reinit();
        build_exp(2, 1000);
        wait_end("t4", 1500);
        tick(100);
        check_seq("t4");
        check("t4_err", 32'(init_error), 32'd1);
        check("t4_erridx", 32'(err_index), 32'd2);
        check("t4_done", 32'(init_done), 32'd0);
        set_policy(0, 0);
        wr_base = wr_q.size();
        pulse_reinit();
        check("t4_err_clr", 32'(init_error), 32'd0);
        build_exp(-1, 0);
        wait_end("t4b", 1500);
        check_seq("t4b");
        check("t4b_done", 32'(init_done), 32'd1);

        // 5: short hpd dip is filtered, long drop clears done and reruns table
        hpd = 1'b0;
        tick(4);
        hpd = 1'b1;
        tick(20);
        check("t5_dip_done", 32'(init_done), 32'd1);
        hpd = 1'b0;
        tick(20);
        check("t5_drop_done", 32'(init_done), 32'd0);
        wr_base = wr_q.size();
        hpd = 1'b1;
        build_exp(-1, 0);
        wait_end("t5", 1500);
        check_seq("t5");
        check("t5_done", 32'(init_done), 32'd1);

        // 6: reinit while entry 5 is on the bus
        wr_base = wr_q.size();
        pulse_reinit();
        wait_writes("t6_reach5", wr_base + 6, 600);
        tick($urandom_range(2, 12));
        pulse_reinit();
        n0 = wr_q.size();
        wait_busy_low("t6_busy", 100);
        check("t6_hold", 32'(wr_q.size() - n0), 32'd0);
        wr_base = n0;
        build_exp(-1, 0);
        wait_end("t6", 1500);
        check_seq("t6");
        check("t6_done", 32'(init_done), 32'd1);

        // 6b: reset in the middle of a transaction
        wr_base = wr_q.size();
        pulse_reinit();
        wait_writes("t6r_reach", wr_base + 3, 300);
        tick(5);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6r");
        reset = 1'b1;
        wr_base = wr_q.size();
        build_exp(-1, 0);
        wait_end("t6r", 1500);
        check_seq("t6r");
        if (wr_q.size() > wr_base) check("t6r_pwrup_hold", 32'(wr_cyc[wr_base] >= PWRUP), 32'd1);

        // Randomized failure patterns
        for (int it = 0; it < 4; it++) begin
            fidx = $urandom_range(0, NUM_REGS - 1);
            nf   = $urandom_range(0, MAX_RETRY + 1);
            set_policy(fidx, nf);
            wr_base = wr_q.size();
            pulse_reinit();
            build_exp(fidx, nf);
            wait_end($sformatf("rnd%0d", it), 1500);
            check_seq($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_err", it), 32'(init_error), 32'(nf > MAX_RETRY));
            if (nf > MAX_RETRY) check($sformatf("rnd%0d_erridx", it), 32'(err_index), 32'(fidx));
            else                check($sformatf("rnd%0d_done", it), 32'(init_done), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
